seg_scan_reader: RTL and testbench

- Time-multiplexed read-out engine for the 8 x 4-bit digit store.
- The digit store is written through num_input/selector/write_enable. This block is its reader: it walks the store round-robin through a synchronous read port and decodes each digit to 7-segment.
- It drives all eight anodes so every stored digit is visible at once, replacing single-digit selector viewing.
- Sits between the digit store's read port and the board display pins.

---
 rtl/seg_scan_reader_if.sv | 10 +
 rtl/seg_scan_reader.sv | 75 +++++++
 tb/tb_seg_scan_reader.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/seg_scan_reader_if.sv
// seg_scan_reader_if: synchronous read port between the scan reader and the digit store
// Signals:
//   rd_addr  3-bit digit slot address, driven by the reader (master)
//   rd_data  4-bit digit value, returned by the store (slave) one clock after rd_addr
interface seg_scan_reader_if;
    logic [2:0] rd_addr;
    logic [3:0] rd_data;
    modport master (output rd_addr, input rd_data);
    modport slave (input rd_addr, output rd_data);
endinterface

// File: rtl/seg_scan_reader.sv
// seg_scan_reader: round-robin 8-digit scanner reading the digit store and driving a 7-segment display
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   enable      scan enable; low keeps the display dark and the scan at slot 0
//   digit_mask  bit i lights digit i
//   rd          digit store read port (rd_addr out, rd_data in, 1-clock latency)
//   seg_output  active-low segments, bit0 = a .. bit6 = g
//   anode_pins  active-low anodes, bit i = digit i
//   frame_done  1-clock pulse after the last slot wraps back to slot 0
module seg_scan_reader #(
    parameter int NUM_DIGITS   = 8,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [7:0]          digit_mask,
    seg_scan_reader_if.master   rd,
    output logic [6:0]          seg_output,
    output logic [7:0]          anode_pins,
    output logic                frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [2:0]    slot_idx_q, slot_idx_d;
    logic [CW-1:0] slot_cnt_q, slot_cnt_d;
    logic [3:0]    digit_reg_q, digit_reg_d;
    logic [2:0]    rd_addr_q;
    logic [6:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;
    logic          fd_q, fd_d;
    logic          last_cnt, last_slot, lit;
    always_comb begin
        last_cnt    = slot_cnt_q == CW'(REFRESH_DIV - 1);
        last_slot   = slot_idx_q == 3'(NUM_DIGITS - 1);
        // digit_reg is valid from slot_cnt = 2, which is why the blank window is at least 2 clocks
        lit         = enable && slot_cnt_q >= CW'(BLANK_CYCLES) && digit_mask[slot_idx_q];
        slot_cnt_d  = (!enable || last_cnt) ? '0 : slot_cnt_q + 1'b1;
        slot_idx_d  = !enable ? '0 : last_cnt ? (last_slot ? '0 : slot_idx_q + 1'b1) : slot_idx_q;
        // the store registered rd_addr during slot_cnt = 0, so its data is valid at slot_cnt = 1
        digit_reg_d = slot_cnt_q == CW'(1) ? rd.rd_data : digit_reg_q;
        an_d        = lit ? ~(8'd1 << slot_idx_q) : 8'hFF;
        seg_d       = lit ? SEG[digit_reg_q] : 7'h7F;
        fd_d        = enable && last_cnt && last_slot;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            slot_idx_q  <= '0;
            slot_cnt_q  <= '0;
            digit_reg_q <= '0;
            rd_addr_q   <= '0;
            seg_q       <= 7'h7F;
            an_q        <= 8'hFF;
            fd_q        <= 1'b0;
        end else begin
            slot_idx_q  <= slot_idx_d;
            slot_cnt_q  <= slot_cnt_d;
            digit_reg_q <= digit_reg_d;
            // tracks the next slot index so the address is already correct at slot_cnt = 0
            rd_addr_q   <= slot_idx_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            fd_q        <= fd_d;
        end
    end
    assign rd.rd_addr = rd_addr_q;
    assign seg_output = seg_q;
    assign anode_pins = an_q;
    assign frame_done = fd_q;
endmodule

// File: tb/tb_seg_scan_reader.sv
// tb_seg_scan_reader: scoreboard bench for seg_scan_reader with a 1-clock-latency digit store
module tb_seg_scan_reader;
    localparam int N = 8, DIV = 8, BL = 2, FRAME = N * DIV;
    logic       clk = 1'b0, reset = 1'b0, enable = 1'b0;
    logic [7:0] digit_mask = 8'hFF;
    logic [6:0] seg_output;
    logic [7:0] anode_pins;
    logic       frame_done;
    logic [3:0] store [8];
    logic [3:0] latched [8];
    logic [18:0] exp_q [$];
    int n_cmp = 0, n_err = 0, k = 0, fd_cnt = 0;

    seg_scan_reader_if bus ();

    seg_scan_reader #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .BLANK_CYCLES(BL)) dut (
        .clk(clk), .reset(reset), .enable(enable), .digit_mask(digit_mask),
        .rd(bus), .seg_output(seg_output), .anode_pins(anode_pins), .frame_done(frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) bus.rd_data <= store[bus.rd_addr];

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // k = enabled edges since the scan (re)started; after edge k the outputs show time k-1
    task automatic tick();
        logic [18:0] e;
        int t, c, s;
        logic lit;
        if (enable) begin
            t = k;
            c = t % DIV;
            s = (t / DIV) % N;
            if (c == 0) latched[s] = store[s];
            lit = c >= BL && digit_mask[s];
            k++;
            e = {lit ? ~(8'd1 << s) : 8'hFF, lit ? seg_of(latched[s]) : 7'h7F,
                 k % FRAME == 0, 3'((k / DIV) % N)};
        end else begin
            k = 0;
            e = {8'hFF, 7'h7F, 1'b0, 3'd0};
        end
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("anode", anode_pins, e[18:11]);
        check("seg", seg_output, e[10:4]);
        check("frame_done", frame_done, e[3]);
        check("rd_addr", bus.rd_addr, e[2:0]);
        check("one_anode", $countones(~anode_pins) <= 1, 1);
        if (frame_done) fd_cnt++;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    initial begin
        store = '{4'h4, 4'h7, 4'h2, 4'h9, 4'h5, 4'h0, 4'h8, 4'hF};
        repeat (3) begin
            @(negedge clk);
            check("rst_an", anode_pins, 8'hFF);
            check("rst_seg", seg_output, 7'h7F);
            check("rst_addr", bus.rd_addr, 0);
            check("rst_fd", frame_done, 0);
        end
        reset = 1'b1;
        ticks(4);
        enable = 1'b1;
        fd_cnt = 0;
        ticks(3);
        check("s0_an", anode_pins, 8'hFE);
        check("s0_seg", seg_output, 7'b0011001);
        ticks(8);
        check("s1_an", anode_pins, 8'hFD);
        check("s1_seg", seg_output, 7'b1111000);
        ticks(16);
        check("s3_an", anode_pins, 8'hF7);
        check("s3_seg", seg_output, 7'b0010000);
        ticks(165);
        check("fd_3frames", fd_cnt, 3);
        digit_mask = 8'h05;
        fd_cnt = 0;
        ticks(128);
        check("fd_masked", fd_cnt, 2);
        digit_mask = 8'hFF;
        ticks(12);
        store[1] = 4'h3;
        ticks(3);
        check("mid_old_seg", seg_output, 7'b1111000);
        ticks(64);
        check("mid_new_an", anode_pins, 8'hFD);
        check("mid_new_seg", seg_output, 7'b0110000);
        ticks(30);
        check("pre_rst_an", anode_pins, 8'hDF);
        #2 reset = 1'b0;
        #1;
        check("async_an", anode_pins, 8'hFF);
        check("async_seg", seg_output, 7'h7F);
        check("async_addr", bus.rd_addr, 0);
        check("async_fd", frame_done, 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_hold_an", anode_pins, 8'hFF);
        reset = 1'b1;
        k = 0;
        ticks(3);
        check("restart_an", anode_pins, 8'hFE);
        ticks(17);
        check("pre_drop_an", anode_pins, 8'hFB);
        enable = 1'b0;
        ticks(1);
        check("drop_an", anode_pins, 8'hFF);
        check("drop_seg", seg_output, 7'h7F);
        ticks(3);
        enable = 1'b1;
        fd_cnt = 0;
        ticks(3);
        check("reen_an", anode_pins, 8'hFE);
        ticks(61);
        check("reen_fd", fd_cnt, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
